// File: rtl/bcd_updown_counter.sv
// Synchronous multi-digit BCD up/down counter with enable, parallel load,
// wrap/saturate limit behaviour and a combinational terminal count for cascading.
module bcd_updown_counter #(
  parameter int unsigned DIGITS   = 4,
  parameter int unsigned SATURATE = 0
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                en,
  input  logic                up,
  input  logic                load,
  input  logic [4*DIGITS-1:0] load_val,
  output logic [4*DIGITS-1:0] count,
  output logic                tc,
  output logic                load_err
);

  localparam int unsigned W = 4 * DIGITS;

  logic [W-1:0] count_step;
  logic         at_max;
  logic         at_min;
  logic         load_ok;
  logic         sat_hold;

  // Next count for one enabled step; a digit moves only when all lower digits
  // sit at the rollover value for the current direction.
  always_comb begin : step_logic
    logic       run9;
    logic       run0;
    logic [3:0] digit;
    run9       = 1'b1;
    run0       = 1'b1;
    digit      = 4'd0;
    count_step = count;
    for (int i = 0; i < int'(DIGITS); i++) begin
      digit = count[4*i +: 4];
      if (up) begin
        if (run9) begin
          count_step[4*i +: 4] = (digit == 4'd9) ? 4'd0 : digit + 4'd1;
        end
      end else begin
        if (run0) begin
          count_step[4*i +: 4] = (digit == 4'd0) ? 4'd9 : digit - 4'd1;
        end
      end
      run9 = run9 & (digit == 4'd9);
      run0 = run0 & (digit == 4'd0);
    end
    at_max = run9;
    at_min = run0;
  end

  // A load is accepted only when every digit of load_val is a legal BCD digit.
  always_comb begin : load_check
    load_ok = 1'b1;
    for (int i = 0; i < int'(DIGITS); i++) begin
      if (load_val[4*i +: 4] > 4'd9) begin
        load_ok = 1'b0;
      end
    end
  end

  // In saturate mode a step past the limit in the current direction is suppressed.
  assign sat_hold = (SATURATE != 0) && (up ? at_max : at_min);

  // Terminal count feeds the next stage's enable in a cascade.
  assign tc = en & (up ? at_max : at_min);

  // Count and load-error registers: reset > load > enable.
  always_ff @(posedge clk) begin
    if (reset) begin
      count    <= '0;
      load_err <= 1'b0;
    end else if (load) begin
      if (load_ok) begin
        count    <= load_val;
        load_err <= 1'b0;
      end else begin
        load_err <= 1'b1;
      end
    end else begin
      load_err <= 1'b0;
      if (en && !sat_hold) begin
        count <= count_step;
      end
    end
  end

endmodule

// File: doc/bcd_updown_counter.md
# bcd_updown_counter

Synchronous, parametrised multi-digit BCD counter. Successor to the single-digit BCD ripple counter: all flops share one clock with no ripple, and it adds up/down direction, count enable, parallel load, a wrap or saturate mode, and a terminal-count output for cascading. It serves as the decimal event/display counter in datapath and test designs, either standalone or chained through `tc`/`en`.

## Interface
- `DIGITS`, 4: number of BCD digits (≥1); count width is 4*DIGITS.
- `SATURATE`, 0: 0 = wrap at the limits, 1 = hold at the limits.
- `clk`  input  1  clock; all state changes on its rising edge.
- `reset`  input  1  synchronous, active-high reset; sampled on the rising edge of `clk`.
- `en`  input  1  count enable.
- `up`  input  1  direction: 1 = increment, 0 = decrement.
- `load`  input  1  parallel load request.
- `load_val`  input  4*DIGITS  BCD value to load; digit 0 is bits [3:0] (least significant).
- `count`  output  4*DIGITS  current BCD count; digit i is bits [4i+3:4i].
- `tc`  output  1  terminal count (combinational), for cascading.
- `load_err`  output  1  registered one-cycle flag: the last load was rejected.

## Operation
- Priority on each rising edge: `reset` > `load` > `en`. With none asserted, `count` holds.
- **Reset:** `count` ← 0, `load_err` ← 0.
- **Load, all digits valid (each ≤ 9):** `count` ← `load_val`, `load_err` ← 0.
- **Load, any digit > 9:**
  - `count` holds.
  - `load_err` ← 1 for one cycle.
  - `en` is ignored in that cycle.
- **Count up** (`en`=1, `up`=1):
  - Digit i increments when every lower digit is 9.
  - A digit that increments from 9 becomes 0.
  - Digit 0 always steps.
- **Count down** (`en`=1, `up`=0):
  - Digit i decrements when every lower digit is 0.
  - A digit that decrements from 0 becomes 9.
- **Limits:** MAX = all digits 9 (10^DIGITS − 1); MIN = all digits 0.
  - `SATURATE`=0: up at MAX wraps to MIN; down at MIN wraps to MAX.
  - `SATURATE`=1: up at MAX holds MAX; down at MIN holds MIN.
- **Terminal count:** `tc` = `en` & (`up` ? count==MAX : count==MIN). It is independent of `load` and `reset`.
- **Cascading:** upper counter `en` = lower counter `tc`, with a shared `up`. The chain then behaves as one wider counter, with no extra cycle between stages.
- `load_err` clears on any edge without a rejected load.
- No digit of `count` ever holds a value above 9. This is an invariant the bench checks every cycle.

## Timing
- `count` and `load_err` are registered; each takes one cycle from the qualifying edge.
- `load_val` is captured on the edge where `load`=1; it is visible on `count` after that edge.
- `tc` is combinational from `count`, `en` and `up`, with no register stage.
  - Example: count 9999, `en`=1, `up`=1 gives `tc`=1 in the same cycle the counter wraps.
- Reset values: `count`=0 and `load_err`=0.
  - `tc` after reset = `en` & ~`up` (count is MIN).
- Reset asserted mid-count or together with `load`/`en` wins: `count`=0 on that edge.
- Changing `up` takes effect on the next edge. A reversal costs no extra cycle: the count steps in the new direction on the next enabled edge.
- Max frequency is set by the DIGITS-deep all-9/all-0 detect chain. Implementers may use a lookahead chain but must not add latency.

## Test plan
- **Reset and count up** (DIGITS=2): `reset` for 1 cycle, then `en`=1, `up`=1 for 100 cycles.
  - `count` steps 00, 01, …, 09, 10, …, 99, 00.
  - `tc`=1 only while `count`=99.
- **Count down with wrap** (DIGITS=2, SATURATE=0): load 01, then `en`=1, `up`=0.
  - `count` goes 01, 00, 99, 98.
  - `tc`=1 while `count`=00.
  - At 10, the next value is 09.
- **Saturate** (DIGITS=2, SATURATE=1): load 98, then count up 3 cycles.
  - `count` goes 98, 99, 99, 99.
  - Then count down from a loaded 00: stays 00, with `tc`=1 while `en`=1.
- **Load validity** (DIGITS=2): load 0x47 → `count`=47 and `load_err`=0. Then load 0x4A with `en`=1 → `count` holds 47 and `load_err`=1 for exactly one cycle.
- **Priority:** with `count`=55, assert `reset`, `load`=1 (load_val 0x12) and `en`=1 together → `count`=00. Next edge, `load` and `en` together → `count`=12.
- **Cascade:** two DIGITS=1 instances, the upper instance's `en` driven by the lower instance's `tc`, shared `up`.
  - The concatenated output matches a DIGITS=2 instance cycle-for-cycle over 250 cycles of random `up` toggling.
